// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  localparam string REP_UNSIGNED = "UNSIGNED";
  localparam string REP_SIGNED   = "SIGNED";

  function automatic int cnt_width(input int widthn);
    return $clog2(widthn + 1);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation, used for operand magnitudes and result re-signing.
module div_sign_fix #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + 1'b1) : i_val;

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: one quotient bit per enabled clock, valid/ready on both sides.
// state | meaning
// IDLE  | waiting for operands, in_ready = clken
// CALC  | shifting/trial-subtracting, counter runs WIDTHN..1
// DONE  | result presented until out_ready
module seq_divider
  import div_pkg::*;
#(
  parameter int    WIDTHN         = 16,
  parameter int    WIDTHD         = 16,
  parameter string REPRESENTATION = "UNSIGNED"
) (
  input  logic              clock,
  input  logic              aclr_n,
  input  logic              clken,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTHN-1:0] numer,
  input  logic [WIDTHD-1:0] denom,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTHN-1:0] quotient,
  output logic [WIDTHD-1:0] remain,
  output logic              div_by_zero
);

  localparam bit            IS_SIGNED = (REPRESENTATION == REP_SIGNED);
  localparam int            CW        = cnt_width(WIDTHN);
  localparam logic [CW-1:0] CNT_INIT  = CW'(WIDTHN);
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);

  div_state_t        r_state;
  logic [CW-1:0]     r_cnt;
  logic [WIDTHN-1:0] r_num;
  logic [WIDTHD-1:0] r_den;
  logic [WIDTHD:0]   r_rem;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_dz;
  logic [WIDTHD-1:0] r_numer_lo;
  logic              r_out_valid;
  logic [WIDTHN-1:0] r_quot;
  logic [WIDTHD-1:0] r_remain;
  logic              r_div0;

  logic              w_numer_neg;
  logic              w_denom_neg;
  logic [WIDTHN-1:0] w_numer_abs;
  logic [WIDTHD-1:0] w_denom_abs;
  logic [WIDTHD+1:0] w_shift;
  logic              w_ge;
  logic [WIDTHD:0]   w_rem_next;
  logic [WIDTHN-1:0] w_quot_mag;
  logic [WIDTHN-1:0] w_quot_signed;
  logic [WIDTHD-1:0] w_rem_signed;

  assign w_numer_neg = IS_SIGNED && numer[WIDTHN-1];
  assign w_denom_neg = IS_SIGNED && denom[WIDTHD-1];

  div_sign_fix #(.W(WIDTHN)) u_abs_numer (.i_val(numer), .i_neg(w_numer_neg), .o_val(w_numer_abs));
  div_sign_fix #(.W(WIDTHD)) u_abs_denom (.i_val(denom), .i_neg(w_denom_neg), .o_val(w_denom_abs));

  // Partial remainder stays below the divisor, so the extra top bit only holds the shifted-in MSB.
  assign w_shift    = {r_rem, r_num[WIDTHN-1]};
  assign w_ge       = (w_shift >= (WIDTHD+2)'(r_den));
  assign w_rem_next = (WIDTHD+1)'(w_ge ? (w_shift - (WIDTHD+2)'(r_den)) : w_shift);
  assign w_quot_mag = {r_num[WIDTHN-2:0], w_ge};

  div_sign_fix #(.W(WIDTHN)) u_sgn_quot (.i_val(w_quot_mag), .i_neg(r_neg_q),
                                         .o_val(w_quot_signed));
  div_sign_fix #(.W(WIDTHD)) u_sgn_rem  (.i_val(w_rem_next[WIDTHD-1:0]), .i_neg(r_neg_r),
                                         .o_val(w_rem_signed));

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_num       <= '0;
      r_den       <= '0;
      r_rem       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
      r_numer_lo  <= '0;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_remain    <= '0;
      r_div0      <= 1'b0;
    end else if (clken) begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_num      <= w_numer_abs;
            r_den      <= w_denom_abs;
            r_rem      <= '0;
            r_neg_q    <= w_numer_neg ^ w_denom_neg;
            r_neg_r    <= w_numer_neg;
            r_dz       <= (denom == '0);
            r_numer_lo <= numer[WIDTHD-1:0];
            r_cnt      <= CNT_INIT;
            r_state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_num <= w_quot_mag;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_quot      <= r_dz ? '1 : w_quot_signed;
            r_remain    <= r_dz ? r_numer_lo : w_rem_signed;
            r_div0      <= r_dz;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE) && clken;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quot;
  assign remain      = r_remain;
  assign div_by_zero = r_div0;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: unsigned and signed instances, vector table, random ops, corner sequences.
module tb_seq_divider;

  localparam int WN = 16;
  localparam int WD = 16;

  logic          clock = 1'b0;
  logic          aclr_n = 1'b0;
  logic          clken = 1'b1;
  logic [1:0]    in_valid;
  logic [1:0]    in_ready;
  logic [1:0]    out_valid;
  logic [1:0]    out_ready;
  logic [1:0]    div_by_zero;
  logic [WN-1:0] numer[2];
  logic [WD-1:0] denom[2];
  logic [WN-1:0] quotient[2];
  logic [WD-1:0] remain[2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  seq_divider #(.WIDTHN(WN), .WIDTHD(WD), .REPRESENTATION("UNSIGNED")) u_div_u (
    .clock(clock), .aclr_n(aclr_n), .clken(clken),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .numer(numer[0]), .denom(denom[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .quotient(quotient[0]), .remain(remain[0]), .div_by_zero(div_by_zero[0])
  );

  seq_divider #(.WIDTHN(WN), .WIDTHD(WD), .REPRESENTATION("SIGNED")) u_div_s (
    .clock(clock), .aclr_n(aclr_n), .clken(clken),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .numer(numer[1]), .denom(denom[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .quotient(quotient[1]), .remain(remain[1]), .div_by_zero(div_by_zero[1])
  );

  typedef struct {
    bit        sgn;
    logic [15:0] n;
    logic [15:0] d;
    logic [15:0] q;
    logic [15:0] r;
    bit        dz;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Division by the arithmetic rules: truncating / and %, all-ones quotient on zero divisor.
  function automatic void model(input bit sgn, input logic [15:0] n, input logic [15:0] d,
                                output logic [15:0] q, output logic [15:0] r, output bit dz);
    int sn, sd;
    if (d == 16'd0) begin
      q = 16'hFFFF; r = n; dz = 1'b1;
    end else if (sgn) begin
      sn = int'($signed(n));
      sd = int'($signed(d));
      q = 16'(sn / sd); r = 16'(sn % sd); dz = 1'b0;
    end else begin
      q = n / d; r = n % d; dz = 1'b0;
    end
  endfunction

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic issue(input int d, input logic [15:0] n, input logic [15:0] dn);
    int t = 0;
    while (!in_ready[d] && t < 64) begin
      @(negedge clock);
      t++;
    end
    check("accept_ready", {31'd0, in_ready[d]}, 32'd1);
    in_valid[d] = 1'b1;
    numer[d] = n;
    denom[d] = dn;
    @(posedge clock);
    #1;
    in_valid[d] = 1'b0;
    numer[d] = 16'($urandom);
    denom[d] = 16'($urandom);
  endtask

  // Counts edges after the accepting edge until out_valid is seen; returns at a negedge.
  task automatic wait_result(input int d, output int lat, output bit busy_low);
    lat = 0;
    busy_low = 1'b1;
    do begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (in_ready[d]) busy_low = 1'b0;
    end while (!out_valid[d] && lat < 200);
  endtask

  task automatic run_and_check(input string tag, input bit sgn, input logic [15:0] n,
                               input logic [15:0] dn, input int exp_lat);
    logic [15:0] eq, er;
    bit edz, busy;
    int lat, d;
    d = sgn ? 1 : 0;
    model(sgn, n, dn, eq, er, edz);
    issue(d, n, dn);
    wait_result(d, lat, busy);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_q"}, {16'd0, quotient[d]}, {16'd0, eq});
    check({tag, "_r"}, {16'd0, remain[d]}, {16'd0, er});
    check({tag, "_dz"}, {31'd0, div_by_zero[d]}, {31'd0, edz});
  endtask

  initial begin
    int lat;
    bit busy;
    in_valid = '0;
    out_ready = 2'b11;
    numer[0] = '0; numer[1] = '0;
    denom[0] = '0; denom[1] = '0;

    vecs.push_back('{0, 16'd1000, 16'd7,      16'd142,  16'd6,    0});
    vecs.push_back('{1, 16'hFFF9, 16'd2,      16'hFFFD, 16'hFFFF, 0});
    vecs.push_back('{1, 16'h8000, 16'hFFFF,   16'h8000, 16'h0000, 0});
    vecs.push_back('{0, 16'd1234, 16'd0,      16'hFFFF, 16'd1234, 1});
    vecs.push_back('{0, 16'd10,   16'd3,      16'd3,    16'd1,    0});
    vecs.push_back('{1, 16'd7,    16'hFFFE,   16'hFFFD, 16'd1,    0});
    vecs.push_back('{1, 16'h8000, 16'd0,      16'hFFFF, 16'h8000, 1});
    vecs.push_back('{0, 16'hFFFF, 16'd1,      16'hFFFF, 16'd0,    0});
    vecs.push_back('{0, 16'd5,    16'd9,      16'd0,    16'd5,    0});
    vecs.push_back('{0, 16'hFFFF, 16'hFFFF,   16'd1,    16'd0,    0});

    #12;
    check("rst_out_valid", {30'd0, out_valid}, 32'd0);
    check("rst_quot0", {16'd0, quotient[0]}, 32'd0);
    check("rst_rem1", {16'd0, remain[1]}, 32'd0);
    check("rst_dz", {30'd0, div_by_zero}, 32'd0);
    @(negedge clock);
    aclr_n = 1'b1;
    @(negedge clock);
    check("idle_in_ready", {30'd0, in_ready}, 32'd3);
    clken = 1'b0;
    #1;
    check("idle_clken0_ready", {30'd0, in_ready}, 32'd0);
    clken = 1'b1;
    @(negedge clock);

    foreach (vecs[i]) begin
      int d;
      d = vecs[i].sgn ? 1 : 0;
      issue(d, vecs[i].n, vecs[i].d);
      wait_result(d, lat, busy);
      check("vec_lat", lat, WN);
      check("vec_busy", {31'd0, busy}, 32'd1);
      check("vec_q", {16'd0, quotient[d]}, {16'd0, vecs[i].q});
      check("vec_r", {16'd0, remain[d]}, {16'd0, vecs[i].r});
      check("vec_dz", {31'd0, div_by_zero[d]}, {31'd0, vecs[i].dz});
      @(posedge clock);
      @(negedge clock);
      check("vec_pop", {31'd0, out_valid[d]}, 32'd0);
      check("vec_ready_after", {31'd0, in_ready[d]}, 32'd1);
    end

    for (int i = 0; i < 60; i++) begin
      logic [15:0] n, dn;
      bit sgn;
      int hold;
      sgn = (i % 2) == 1;
      n = 16'($urandom);
      dn = 16'($urandom);
      if ($urandom_range(0, 2) == 0) dn = 16'($urandom_range(1, 20));
      if ($urandom_range(0, 9) == 0) dn = 16'd0;
      if ($urandom_range(0, 9) == 0) n = 16'h8000;
      hold = $urandom_range(0, 3);
      out_ready[sgn] = (hold == 0);
      run_and_check("rnd", sgn, n, dn, WN);
      for (int k = 0; k < hold; k++) begin
        @(posedge clock);
        @(negedge clock);
        check("rnd_hold", {31'd0, out_valid[sgn]}, 32'd1);
      end
      out_ready[sgn] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("rnd_pop", {31'd0, out_valid[sgn]}, 32'd0);
    end

    out_ready[0] = 1'b0;
    run_and_check("bp", 0, 16'd1000, 16'd7, WN);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      @(negedge clock);
      check("bp_valid", {31'd0, out_valid[0]}, 32'd1);
      check("bp_q", {16'd0, quotient[0]}, 32'd142);
      check("bp_r", {16'd0, remain[0]}, 32'd6);
      check("bp_ready", {31'd0, in_ready[0]}, 32'd0);
    end
    out_ready[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("bp_pop", {31'd0, out_valid[0]}, 32'd0);
    check("bp_ready_after", {31'd0, in_ready[0]}, 32'd1);

    // Stall for three edges mid-calculation, then a one-cycle stall while DONE.
    fork
      run_and_check("stall", 0, 16'd1000, 16'd7, WN + 3);
      begin
        repeat (5) @(negedge clock);
        clken = 1'b0;
        repeat (3) @(negedge clock);
        clken = 1'b1;
      end
    join
    clken = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("done_clken0_valid", {31'd0, out_valid[0]}, 32'd1);
    check("done_clken0_ready", {31'd0, in_ready[0]}, 32'd0);
    check("done_clken0_q", {16'd0, quotient[0]}, 32'd142);
    clken = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("done_pop", {31'd0, out_valid[0]}, 32'd0);
    check("done_ready", {31'd0, in_ready[0]}, 32'd1);

    issue(0, 16'd1000, 16'd7);
    repeat (5) @(posedge clock);
    @(negedge clock);
    #2;
    aclr_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid[0]}, 32'd0);
    check("arst_q", {16'd0, quotient[0]}, 32'd0);
    check("arst_r", {16'd0, remain[0]}, 32'd0);
    #1;
    aclr_n = 1'b1;
    @(negedge clock);
    check("arst_ready", {31'd0, in_ready[0]}, 32'd1);
    repeat (20) @(negedge clock);
    check("arst_no_result", {31'd0, out_valid[0]}, 32'd0);
    run_and_check("post_rst", 0, 16'd100, 16'd10, WN);
    @(posedge clock);
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
